avalon_dram_responder: RTL



---
 rtl/avalon_dram_responder.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/avalon_dram_responder.sv
// Avalon-MM burst slave backed by an on-chip word array; it stands in for the external DRAM controller.
// Read beats come back in order with a fixed latency. Optional LFSR stalls exercise the master's waitrequest handling.
module avalon_dram_responder #(
  parameter int unsigned DATA_WIDTH   = 512,
  parameter int unsigned ADDR_WIDTH   = 26,
  parameter int unsigned BURST_WIDTH  = 4,
  parameter int unsigned MEM_LOG2     = 12,
  parameter int unsigned READ_LATENCY = 4,
  parameter bit          STALL_EN     = 1'b0,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    avl_dram_read,
  input  logic                    avl_dram_write,
  input  logic [DATA_WIDTH-1:0]   avl_dram_writedata,
  input  logic [ADDR_WIDTH-1:0]   avl_dram_address,
  input  logic [DATA_WIDTH/8-1:0] avl_dram_byteen,
  input  logic [BURST_WIDTH-1:0]  avl_dram_burstcount,
  output logic [DATA_WIDTH-1:0]   avl_dram_readdata,
  output logic                    avl_dram_readdatavalid,
  output logic                    avl_dram_waitrequest,
  output logic                    protocol_err
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned DEPTH    = 1 << MEM_LOG2;

  typedef enum logic [1:0] {IDLE, WR, RD} state_e;

  state_e                 state_q, state_d;
  logic [MEM_LOG2-1:0]    addr_q, addr_d;
  logic [BURST_WIDTH-1:0] rem_q, rem_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic                   wait_q, wait_d;
  logic                   err_q, err_d;

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic                   we;
  logic [MEM_LOG2-1:0]    wr_idx;
  logic                   issue;
  logic [BURST_WIDTH-1:0] len;

  logic [READ_LATENCY-1:0] vld_q;
  logic [DATA_WIDTH-1:0]   dat_q [READ_LATENCY];

  logic unused_addr_hi;
  assign unused_addr_hi = ^avl_dram_address[ADDR_WIDTH-1:MEM_LOG2];

  assign len = (avl_dram_burstcount == '0) ? BURST_WIDTH'(1) : avl_dram_burstcount;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    err_d   = err_q;
    we      = 1'b0;
    wr_idx  = addr_q;
    issue   = 1'b0;
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    unique case (state_q)
      IDLE: begin
        if (!wait_q && avl_dram_write) begin
          we      = 1'b1;
          wr_idx  = avl_dram_address[MEM_LOG2-1:0];
          addr_d  = wr_idx + MEM_LOG2'(1);
          rem_d   = len - BURST_WIDTH'(1);
          state_d = (len == BURST_WIDTH'(1)) ? IDLE : WR;
          if (avl_dram_read) err_d = 1'b1;
        end else if (!wait_q && avl_dram_read) begin
          addr_d  = avl_dram_address[MEM_LOG2-1:0];
          rem_d   = len;
          state_d = RD;
        end
      end
      WR: begin
        if (avl_dram_read) err_d = 1'b1;
        if (!wait_q && avl_dram_write) begin
          we     = 1'b1;
          addr_d = addr_q + MEM_LOG2'(1);
          rem_d  = rem_q - BURST_WIDTH'(1);
          if (rem_q == BURST_WIDTH'(1)) state_d = IDLE;
        end
      end
      RD: begin
        issue  = 1'b1;
        addr_d = addr_q + MEM_LOG2'(1);
        rem_d  = rem_q - BURST_WIDTH'(1);
        if (rem_q == BURST_WIDTH'(1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // waitrequest is registered as the same function of the next state and LFSR
    wait_d = (state_d == RD) | (STALL_EN & (lfsr_d[1:0] == 2'b00));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      lfsr_q  <= LFSR_SEED;
      wait_q  <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      lfsr_q  <= lfsr_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clock) begin
    if (we && !reset) begin
      for (int unsigned b = 0; b < BE_WIDTH; b++) begin
        if (avl_dram_byteen[b]) mem[wr_idx][8*b +: 8] <= avl_dram_writedata[8*b +: 8];
      end
    end
  end

  // Stage 0 is the synchronous array read; later stages only delay.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
      for (int unsigned i = 0; i < READ_LATENCY; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= issue;
      if (issue) dat_q[0] <= mem[addr_q];
      for (int unsigned i = 1; i < READ_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign avl_dram_readdata      = dat_q[READ_LATENCY-1];
  assign avl_dram_readdatavalid = vld_q[READ_LATENCY-1];
  assign avl_dram_waitrequest   = wait_q;
  assign protocol_err           = err_q;

endmodule
